cp0_int_ctrl: RTL and testbench

- Parametrised coprocessor-0 for the multi-cycle MIPS core: Status/Cause/EPC/BadVAddr/Count/Compare, vectored exception entry, ERET return, prioritised hardware and timer interrupts.
- Sits beside the GPR file and PC.
- The controller drives mfc0/mtc0/exc_req/eret; the PC mux consumes redirect/exc_addr.
- Adds to the previous CP0:
  - N synchronised external interrupt lines with masks
  - Count/Compare timer
  - EXL nesting semantics
  - delay-slot EPC correction
  - BadVAddr capture

---
 rtl/cp0_pkg.sv | 36 +++
 rtl/cp0_int_ctrl_if.sv | 33 +++
 rtl/cp0_timer.sv | 62 ++++++
 rtl/cp0_int_ctrl.sv | 150 +++++++++++++++
 tb/tb_cp0_int_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 interrupt controller: register indices,
// Status/Cause bit positions and exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    localparam int CA_CODE_LO = 2;
    localparam int CA_IP_LO   = 8;
    localparam int CA_BD      = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Only address-error exceptions carry a meaningful faulting address.
    function automatic logic has_bad_vaddr(input logic [4:0] code);
        return (code == 5'(EXC_ADEL)) || (code == 5'(EXC_ADES));
    endfunction

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Controller/PC-mux facing bundle of the CP0 block; master is the core
// controller side, slave is the CP0 itself.
interface cp0_int_ctrl_if;
    logic        mfc0;
    logic        mtc0;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] bad_vaddr;
    logic        eret;
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] epc;
    logic        timer_int;
    logic        int_pending;
    logic        redirect;
    logic [31:0] exc_addr;

    modport master (
        output mfc0, mtc0, rd_addr, wdata, pc, in_delay_slot,
               exc_req, exc_code, bad_vaddr, eret,
        input  rdata, status, epc, timer_int, int_pending, redirect, exc_addr
    );

    modport slave (
        input  mfc0, mtc0, rd_addr, wdata, pc, in_delay_slot,
               exc_req, exc_code, bad_vaddr, eret,
        output rdata, status, epc, timer_int, int_pending, redirect, exc_addr
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and a sticky
// match flag cleared by rewriting Compare.
module cp0_timer #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div_reg, div_next;
    logic [31:0]      count_reg, count_next;
    logic [31:0]      compare_reg, compare_next;
    logic             pend_reg, pend_next;
    logic             tick;
    logic [31:0]      count_inc;

    always_comb begin
        tick         = (div_reg == DIV_W'(COUNT_DIV - 1));
        div_next     = tick ? '0 : div_reg + DIV_W'(1);
        count_inc    = count_reg + 32'd1;
        count_next   = count_reg;
        compare_next = compare_reg;
        pend_next    = pend_reg;
        if (count_we)
            count_next = wdata;
        else if (tick)
            count_next = count_inc;
        if (compare_we)
            compare_next = wdata;
        // Only a real increment landing on Compare raises the flag; a software
        // load of Count does not.
        if (compare_we)
            pend_next = 1'b0;
        else if (tick && !count_we && (count_inc == compare_reg))
            pend_next = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg     <= '0;
            count_reg   <= '0;
            compare_reg <= '0;
            pend_reg    <= 1'b0;
        end else begin
            div_reg     <= div_next;
            count_reg   <= count_next;
            compare_reg <= compare_next;
            pend_reg    <= pend_next;
        end
    end

    assign count     = count_reg;
    assign compare   = compare_reg;
    assign timer_int = pend_reg;
endmodule

// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0 for the multi-cycle MIPS core: exception entry/return,
// synchronised hardware interrupts, software interrupts and the CP0 timer.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT   = 6,
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter logic [31:0] RESET_STATUS = 32'h0000_0001,
    parameter int          COUNT_DIV    = 1,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] hw_int,
    cp0_int_ctrl_if.slave         bus
);
    logic [NUM_HW_INT-1:0] hw_sync;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HW_INT; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    chain_reg <= '0;
                else
                    chain_reg <= SYNC_STAGES'({chain_reg, hw_int[gi]});
            end
            assign hw_sync[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic [31:0] status_reg, status_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] badv_reg, badv_next;
    logic        bd_reg, bd_next;
    logic [4:0]  code_reg, code_next;
    logic [1:0]  ip_sw_reg, ip_sw_next;
    logic        redirect_reg, redirect_next;
    logic [31:0] exc_addr_reg, exc_addr_next;

    logic [31:0] count, compare;
    logic        timer_int;
    logic [7:0]  ip;
    logic        int_pending;
    logic        take_entry, take_eret, take_mtc0;
    logic [4:0]  entry_code;
    logic [31:0] cause;
    logic        unused_mfc0;

    assign unused_mfc0 = bus.mfc0;

    // With six lines, hw_int[5] shares IP7 with the timer.
    assign ip    = (8'(hw_sync) << 2) | {timer_int, 5'b0, ip_sw_reg};
    assign cause = {bd_reg, 15'b0, ip, 1'b0, code_reg, 2'b0};

    always_comb begin
        int_pending = status_reg[ST_IE] & ~status_reg[ST_EXL]
                    & (|(ip & status_reg[ST_IM_HI:ST_IM_LO]));
        take_entry  = bus.exc_req | int_pending;
        take_eret   = bus.eret & ~take_entry;
        take_mtc0   = bus.mtc0 & ~take_entry & ~bus.eret;
        entry_code  = bus.exc_req ? bus.exc_code : 5'(EXC_INT);
    end

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (take_mtc0 && (bus.rd_addr == REG_COUNT)),
        .compare_we (take_mtc0 && (bus.rd_addr == REG_COMPARE)),
        .wdata      (bus.wdata),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );

    always_comb begin
        status_next   = status_reg;
        epc_next      = epc_reg;
        badv_next     = badv_reg;
        bd_next       = bd_reg;
        code_next     = code_reg;
        ip_sw_next    = ip_sw_reg;
        redirect_next = take_entry | take_eret;
        exc_addr_next = exc_addr_reg;
        if (take_entry) begin
            code_next           = entry_code;
            status_next[ST_EXL] = 1'b1;
            exc_addr_next       = EXC_VECTOR;
            // A nested entry keeps the outer handler's return state.
            if (!status_reg[ST_EXL]) begin
                epc_next = bus.in_delay_slot ? bus.pc - 32'd4 : bus.pc;
                bd_next  = bus.in_delay_slot;
            end
            if (has_bad_vaddr(entry_code))
                badv_next = bus.bad_vaddr;
        end else if (take_eret) begin
            status_next[ST_EXL] = 1'b0;
            exc_addr_next       = epc_reg;
        end else if (take_mtc0) begin
            case (bus.rd_addr)
                REG_STATUS: status_next = bus.wdata;
                REG_CAUSE:  ip_sw_next  = bus.wdata[CA_IP_LO+1:CA_IP_LO];
                REG_EPC:    epc_next    = bus.wdata;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_reg   <= RESET_STATUS;
            epc_reg      <= '0;
            badv_reg     <= '0;
            bd_reg       <= 1'b0;
            code_reg     <= '0;
            ip_sw_reg    <= '0;
            redirect_reg <= 1'b0;
            exc_addr_reg <= '0;
        end else begin
            status_reg   <= status_next;
            epc_reg      <= epc_next;
            badv_reg     <= badv_next;
            bd_reg       <= bd_next;
            code_reg     <= code_next;
            ip_sw_reg    <= ip_sw_next;
            redirect_reg <= redirect_next;
            exc_addr_reg <= exc_addr_next;
        end
    end

    always_comb begin
        case (bus.rd_addr)
            REG_BADVADDR: bus.rdata = badv_reg;
            REG_COUNT:    bus.rdata = count;
            REG_COMPARE:  bus.rdata = compare;
            REG_STATUS:   bus.rdata = status_reg;
            REG_CAUSE:    bus.rdata = cause;
            REG_EPC:      bus.rdata = epc_reg;
            default:      bus.rdata = 32'd0;
        endcase
    end

    assign bus.status      = status_reg;
    assign bus.epc         = epc_reg;
    assign bus.timer_int   = timer_int;
    assign bus.int_pending = int_pending;
    assign bus.redirect    = redirect_reg;
    assign bus.exc_addr    = exc_addr_reg;
endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed and randomised checks of cp0_int_ctrl against a register-level
// reference model of CP0 behaviour.
module tb_cp0_int_ctrl;
    localparam int          NHW  = 6;
    localparam int          SYNC = 2;
    localparam int          DIV  = 1;
    localparam logic [31:0] VEC  = 32'h0040_0004;
    localparam logic [31:0] RST_ST = 32'h0000_0001;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NHW-1:0] hw_int = '0;
    int             errors = 0;
    int             checks = 0;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl #(
        .NUM_HW_INT   (NHW),
        .EXC_VECTOR   (VEC),
        .RESET_STATUS (RST_ST),
        .COUNT_DIV    (DIV),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .hw_int (hw_int),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]    m_status, m_epc, m_badv, m_count, m_compare, m_exc_addr;
    logic           m_bd, m_tpend, m_redirect;
    logic [4:0]     m_code;
    logic [1:0]     m_sw;
    int             m_div;
    logic [NHW-1:0] hw_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_status = RST_ST; m_epc = '0; m_badv = '0; m_count = '0; m_compare = '0;
        m_exc_addr = '0; m_bd = 0; m_tpend = 0; m_redirect = 0; m_code = '0;
        m_sw = '0; m_div = 0;
        hw_q.delete();
        for (int i = 0; i < SYNC; i++) hw_q.push_back('0);
    endtask

    function automatic logic [7:0] m_ip();
        logic [7:0] hw8;
        hw8 = 8'(hw_q[SYNC-1]) << 2;
        return hw8 | {m_tpend, 5'b0, m_sw};
    endfunction

    function automatic logic m_intp();
        return m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 8'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return {m_bd, 15'b0, m_ip(), 1'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic       entry, do_eret, do_w, tick;
        logic [4:0] code;
        entry   = bus.exc_req || m_intp();
        do_eret = !entry && bus.eret;
        do_w    = !entry && !bus.eret && bus.mtc0;
        code    = bus.exc_req ? bus.exc_code : 5'd0;
        tick    = (m_div == DIV - 1);
        m_div   = tick ? 0 : m_div + 1;
        if (do_w && bus.rd_addr == 5'd11) begin
            m_compare = bus.wdata;
            m_tpend   = 1'b0;
        end else if (tick && !(do_w && bus.rd_addr == 5'd9) && (m_count + 32'd1 == m_compare)) begin
            m_tpend = 1'b1;
        end
        if (do_w && bus.rd_addr == 5'd9) m_count = bus.wdata;
        else if (tick) m_count = m_count + 32'd1;
        m_redirect = entry || do_eret;
        if (entry) begin
            m_code = code;
            if (!m_status[1]) begin
                m_epc = bus.in_delay_slot ? bus.pc - 32'd4 : bus.pc;
                m_bd  = bus.in_delay_slot;
            end
            m_status[1] = 1'b1;
            if (code == 5'd4 || code == 5'd5) m_badv = bus.bad_vaddr;
            m_exc_addr = VEC;
        end else if (do_eret) begin
            m_status[1] = 1'b0;
            m_exc_addr  = m_epc;
        end else if (do_w) begin
            if (bus.rd_addr == 5'd12) m_status = bus.wdata;
            if (bus.rd_addr == 5'd13) m_sw = bus.wdata[9:8];
            if (bus.rd_addr == 5'd14) m_epc = bus.wdata;
        end
        hw_q.push_front(hw_int);
        void'(hw_q.pop_back());
    endtask

    task automatic idle();
        bus.mfc0 = 0; bus.mtc0 = 0; bus.rd_addr = '0; bus.wdata = '0; bus.pc = '0;
        bus.in_delay_slot = 0; bus.exc_req = 0; bus.exc_code = '0;
        bus.bad_vaddr = '0; bus.eret = 0;
    endtask

    // Called at a falling edge with inputs applied; compares, clocks, updates model.
    task automatic tick();
        #1;
        check("rdata", bus.rdata, m_read(bus.rd_addr));
        check("int_pending", 32'(bus.int_pending), 32'(m_intp()));
        check("status", bus.status, m_status);
        check("epc", bus.epc, m_epc);
        check("timer_int", 32'(bus.timer_int), 32'(m_tpend));
        check("redirect", 32'(bus.redirect), 32'(m_redirect));
        check("exc_addr", bus.exc_addr, m_exc_addr);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        bus.rd_addr = a;
        #1;
        v = bus.rdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle(); bus.mtc0 = 1; bus.rd_addr = a; bus.wdata = d;
        tick(); idle();
    endtask

    task automatic exc(input logic [31:0] pc, input logic ds, input logic [4:0] code);
        idle(); bus.exc_req = 1; bus.pc = pc; bus.in_delay_slot = ds; bus.exc_code = code;
        bus.bad_vaddr = 32'hDEAD_0000 | 32'(code);
        tick(); idle();
    endtask

    task automatic do_eret();
        idle(); bus.eret = 1; tick(); idle();
    endtask

    initial begin
        logic [31:0] v;
        logic [4:0]  wa;
        logic [4:0]  addrs[8];
        logic [4:0]  codes[7];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd20};
        codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        rd_reg(5'd12, v); check("reset_status", v, 32'h1);
        rd_reg(5'd13, v); check("reset_cause", v, 32'h0);
        rd_reg(5'd14, v); check("reset_epc", v, 32'h0);
        check("reset_redirect", 32'(bus.redirect), 32'h0);

        exc(32'h0040_0100, 0, 5'd8);
        check("sys_redirect", 32'(bus.redirect), 32'h1);
        check("sys_vec", bus.exc_addr, 32'h0040_0004);
        check("sys_epc", bus.epc, 32'h0040_0100);
        rd_reg(5'd13, v); check("sys_code", 32'(v[6:2]), 32'd8);
        check("sys_status", bus.status, 32'h3);
        do_eret();
        check("eret_addr", bus.exc_addr, 32'h0040_0100);
        check("eret_status", bus.status, 32'h1);
        tick();
        check("redirect_drop", 32'(bus.redirect), 32'h0);

        exc(32'h0040_0200, 1, 5'd12);
        check("ds_epc", bus.epc, 32'h0040_01FC);
        rd_reg(5'd13, v); check("ds_bd", 32'(v[31]), 32'h1);
        exc(32'h0040_0300, 0, 5'd10);
        check("nest_epc", bus.epc, 32'h0040_01FC);
        rd_reg(5'd13, v); check("nest_code", 32'(v[6:2]), 32'd10);
        check("nest_redirect", 32'(bus.redirect), 32'h1);

        #2 rst = 1;
        #1;
        check("async_rst_status", bus.status, 32'h1);
        check("async_rst_redirect", 32'(bus.redirect), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 0;

        wr(5'd12, 32'h0000_0401);
        exc(32'h0040_0400, 0, 5'd9);
        do_eret();
        hw_int = 6'b000001;
        tick();
        check("irq_lat1", 32'(bus.int_pending), 32'h0);
        tick();
        check("irq_lat2", 32'(bus.int_pending), 32'h1);
        tick();
        rd_reg(5'd13, v); check("irq_code", 32'(v[6:2]), 32'd0);
        check("irq_redirect", 32'(bus.redirect), 32'h1);
        check("irq_status", bus.status, 32'h0000_0403);
        do_eret();
        check("irq_again", 32'(bus.int_pending), 32'h1);
        exc(32'h0040_0500, 0, 5'd8);
        rd_reg(5'd13, v); check("exc_over_irq", 32'(v[6:2]), 32'd8);
        wr(5'd12, 32'h0000_0001);
        check("irq_masked", 32'(bus.int_pending), 32'h0);
        hw_int = '0;
        repeat (3) tick();

        wr(5'd11, 32'd10);
        wr(5'd9, 32'd7);
        tick(); tick();
        check("timer_early", 32'(bus.timer_int), 32'h0);
        tick();
        check("timer_hit", 32'(bus.timer_int), 32'h1);
        rd_reg(5'd9, v); check("timer_count", v, 32'd10);
        wr(5'd11, 32'd20);
        check("timer_clear", 32'(bus.timer_int), 32'h0);
        wr(5'd9, 32'hFFFF_FFFF);
        rd_reg(5'd9, v); check("count_max", v, 32'hFFFF_FFFF);
        tick();
        rd_reg(5'd9, v); check("count_wrap", v, 32'h0);

        wr(5'd13, 32'hFFFF_FFFF);
        rd_reg(5'd13, v); check("cause_sw_only", v, 32'h0000_0320);
        wr(5'd12, 32'h0000_0101);
        check("sw_pending", 32'(bus.int_pending), 32'h1);
        tick();
        rd_reg(5'd13, v); check("sw_code", 32'(v[6:2]), 32'd0);
        check("sw_redirect", 32'(bus.redirect), 32'h1);
        wr(5'd13, 32'h0);
        do_eret();

        for (int n = 0; n < 3000; n++) begin
            idle();
            bus.rd_addr = 5'($urandom_range(0, 31));
            bus.mfc0    = 1'($urandom_range(0, 1));
            bus.pc      = $urandom & 32'hFFFF_FFFC;
            bus.in_delay_slot = 1'($urandom_range(0, 1));
            bus.bad_vaddr = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = NHW'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                bus.exc_req  = 1;
                bus.exc_code = codes[$urandom_range(0, 6)];
            end
            if ($urandom_range(0, 11) == 0) bus.eret = 1;
            if ($urandom_range(0, 4) == 0) begin
                wa = addrs[$urandom_range(0, 7)];
                bus.mtc0 = 1;
                bus.rd_addr = wa;
                bus.wdata = $urandom;
                if (wa == 5'd12) bus.wdata = bus.wdata & 32'h0000_FF03;
                if (wa == 5'd9 && $urandom_range(0, 1) == 1)
                    bus.wdata = m_compare - 32'($urandom_range(0, 4));
                if (wa == 5'd11 && $urandom_range(0, 1) == 1)
                    bus.wdata = m_count + 32'($urandom_range(1, 6));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
